// File: rtl/aes_sr_column_feeder.sv
// AES ShiftRows column feeder.
// Captures a 128-bit AES state (optionally applying ShiftRows on the way in)
// and hands it to a single-column MixColumns stage one 32-bit column per
// transfer. Handshakes use valid/ready on both sides. A new state can be
// accepted on the same cycle the last column leaves, so a continuous stream
// costs exactly four cycles per state.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | nothing held; in_ready=1, waiting for an input transfer
// EMIT  | state held; presenting column idx on out_col
module aes_sr_column_feeder #(
  parameter int SHIFT_EN = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [31:0]  out_col,
  output logic [1:0]   out_idx,
  output logic         out_last_col,
  output logic         out_bypass
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } fsm_t;

  fsm_t         fsm_q, fsm_d;
  logic [1:0]   idx_q, idx_d;
  logic [127:0] state_q, state_d;
  logic         last_q, last_d;
  logic [31:0]  col_q, col_d;

  logic [127:0] shifted;
  logic         in_xfer;
  logic         out_xfer;

  // Column c of a 128-bit state lives at bits [32c +: 32].
  function automatic logic [31:0] col_of(input logic [127:0] s, input logic [1:0] i);
    logic [31:0] r;
    case (i)
      2'd0:    r = s[31:0];
      2'd1:    r = s[63:32];
      2'd2:    r = s[95:64];
      default: r = s[127:96];
    endcase
    return r;
  endfunction

  // Byte routing at capture: row r of column c comes from column (c+r) mod 4
  // when ShiftRows is enabled, otherwise straight through.
  always_comb begin
    shifted = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (SHIFT_EN != 0)
          shifted[32*c+8*r +: 8] = in_state[32*((c+r)%4)+8*r +: 8];
        else
          shifted[32*c+8*r +: 8] = in_state[32*c+8*r +: 8];
      end
    end
  end

  // State register and datapath flops; reset discards any held state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= ST_IDLE;
      idx_q   <= 2'd0;
      state_q <= '0;
      last_q  <= 1'b0;
      col_q   <= '0;
    end else begin
      fsm_q   <= fsm_d;
      idx_q   <= idx_d;
      state_q <= state_d;
      last_q  <= last_d;
      col_q   <= col_d;
    end
  end

  // Next-state: capture, advance through columns, chain or return to IDLE.
  always_comb begin
    fsm_d    = fsm_q;
    idx_d    = idx_q;
    state_d  = state_q;
    last_d   = last_q;
    col_d    = col_q;
    in_xfer  = in_valid && in_ready;
    out_xfer = out_valid && out_ready;
    case (fsm_q)
      ST_IDLE: begin
        if (in_xfer) begin
          fsm_d   = ST_EMIT;
          idx_d   = 2'd0;
          state_d = shifted;
          last_d  = in_last;
          col_d   = shifted[31:0];
        end
      end
      default: begin
        if (out_xfer) begin
          if (idx_q != 2'd3) begin
            idx_d = idx_q + 2'd1;
            col_d = col_of(state_q, idx_q + 2'd1);
          end else if (in_xfer) begin
            // Back-to-back: last column leaves as the next state arrives.
            idx_d   = 2'd0;
            state_d = shifted;
            last_d  = in_last;
            col_d   = shifted[31:0];
          end else begin
            fsm_d = ST_IDLE;
          end
        end
      end
    endcase
  end

  // Handshake outputs decoded from the FSM state and column index.
  always_comb begin
    in_ready     = 1'b1;
    out_valid    = 1'b0;
    out_last_col = 1'b0;
    if (fsm_q == ST_EMIT) begin
      out_valid    = 1'b1;
      in_ready     = (idx_q == 2'd3) && out_ready;
      out_last_col = (idx_q == 2'd3);
    end
  end

  assign out_col    = col_q;
  assign out_idx    = idx_q;
  assign out_bypass = last_q;

endmodule

// File: tb/tb_aes_sr_column_feeder.sv
// Directed bench for aes_sr_column_feeder: one instance with ShiftRows
// enabled and one without, both driven from the same stimulus.
module tb_aes_sr_column_feeder;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic [127:0] in_state;
  logic         in_last;
  logic         out_ready;

  logic         in_ready1, out_valid1, out_last_col1, out_bypass1;
  logic [31:0]  out_col1;
  logic [1:0]   out_idx1;
  logic         in_ready0, out_valid0, out_last_col0, out_bypass0;
  logic [31:0]  out_col0;
  logic [1:0]   out_idx0;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [127:0] S_FIPS = 128'h3052411e_e55db4b8_f198bfe0_ae1127d4;
  localparam logic [127:0] S_B    = 128'h00112233_44556677_8899aabb_ccddeeff;

  logic [31:0] exp_fips_sh [4];
  logic [31:0] exp_fips_ns [4];
  logic [31:0] exp_b_sh    [4];
  logic [31:0] exp_b_ns    [4];
  logic [15:0] stall_pat;

  aes_sr_column_feeder #(.SHIFT_EN(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .in_state(in_state), .in_last(in_last), .out_valid(out_valid1),
    .out_ready(out_ready), .out_col(out_col1), .out_idx(out_idx1),
    .out_last_col(out_last_col1), .out_bypass(out_bypass1)
  );

  aes_sr_column_feeder #(.SHIFT_EN(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .in_state(in_state), .in_last(in_last), .out_valid(out_valid0),
    .out_ready(out_ready), .out_col(out_col0), .out_idx(out_idx0),
    .out_last_col(out_last_col0), .out_bypass(out_bypass0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int eidx;
    exp_fips_sh = '{32'h305dbfd4, 32'hae52b4e0, 32'hf11141b8, 32'he598271e};
    exp_fips_ns = '{32'hae1127d4, 32'hf198bfe0, 32'he55db4b8, 32'h3052411e};
    exp_b_sh    = '{32'h0055aaff, 32'hcc1166bb, 32'h88dd2277, 32'h4499ee33};
    exp_b_ns    = '{32'hccddeeff, 32'h8899aabb, 32'h44556677, 32'h00112233};
    stall_pat   = 16'b1110_0110_1001_0100;

    rst_n = 1'b1; in_valid = 1'b0; in_state = '0; in_last = 1'b0; out_ready = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    check("rst_out_valid", {31'd0, out_valid1}, 32'd0);
    check("rst_out_col", out_col1, 32'd0);
    check("rst_out_idx", {30'd0, out_idx1}, 32'd0);
    check("rst_out_bypass", {31'd0, out_bypass1}, 32'd0);
    check("rst_out_last_col", {31'd0, out_last_col1}, 32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    check("post_rst_in_ready", {31'd0, in_ready1}, 32'd1);

    // FIPS-197 round-1 state, no stalls, both shift settings.
    @(negedge clk);
    in_valid = 1'b1; in_state = S_FIPS; in_last = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      check("fips_valid", {31'd0, out_valid1}, 32'd1);
      check("fips_sh_col", out_col1, exp_fips_sh[i]);
      check("fips_ns_col", out_col0, exp_fips_ns[i]);
      check("fips_idx", {30'd0, out_idx1}, i);
      check("fips_last_col", {31'd0, out_last_col1}, (i == 3) ? 32'd1 : 32'd0);
      check("fips_in_ready", {31'd0, in_ready1}, (i == 3) ? 32'd1 : 32'd0);
      check("fips_bypass", {31'd0, out_bypass1}, 32'd0);
    end
    @(negedge clk);
    check("fips_done_valid", {31'd0, out_valid1}, 32'd0);
    check("fips_done_in_ready", {31'd0, in_ready1}, 32'd1);

    // Back-to-back: FIPS state with in_last=1, then B with in_last=0 held
    // while in_ready is low.
    in_valid = 1'b1; in_state = S_FIPS; in_last = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 0) begin
        in_state = S_B; in_last = 1'b0;
      end
      if (k == 4) in_valid = 1'b0;
      check("b2b_valid", {31'd0, out_valid1}, 32'd1);
      check("b2b_idx", {30'd0, out_idx1}, k % 4);
      check("b2b_sh_col", out_col1, (k < 4) ? exp_fips_sh[k] : exp_b_sh[k-4]);
      check("b2b_ns_col", out_col0, (k < 4) ? exp_fips_ns[k] : exp_b_ns[k-4]);
      check("b2b_bypass", {31'd0, out_bypass1}, (k < 4) ? 32'd1 : 32'd0);
      check("b2b_in_ready", {31'd0, in_ready1}, (k % 4 == 3) ? 32'd1 : 32'd0);
    end
    @(negedge clk);
    check("b2b_done_valid", {31'd0, out_valid1}, 32'd0);

    // Downstream stalls: each column must hold until accepted, in order.
    in_valid = 1'b1; in_state = S_B; in_last = 1'b0; out_ready = 1'b0;
    eidx = 0;
    for (int cyc = 0; cyc < 40 && eidx < 4; cyc++) begin
      @(negedge clk);
      in_valid = 1'b0;
      check("stall_valid", {31'd0, out_valid1}, 32'd1);
      check("stall_idx", {30'd0, out_idx1}, eidx);
      check("stall_col", out_col1, exp_b_sh[eidx]);
      out_ready = (cyc < 16) ? stall_pat[cyc] : 1'b1;
      if (out_ready) eidx++;
    end
    check("stall_all_cols", eidx, 32'd4);
    @(negedge clk);
    check("stall_done_valid", {31'd0, out_valid1}, 32'd0);

    // Asynchronous reset mid-EMIT at idx 2, then capture on first edge.
    out_ready = 1'b1;
    in_valid = 1'b1; in_state = S_FIPS; in_last = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid_idx_before_rst", {30'd0, out_idx1}, 32'd2);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {31'd0, out_valid1}, 32'd0);
    check("mid_rst_col", out_col1, 32'd0);
    check("mid_rst_idx", {30'd0, out_idx1}, 32'd0);
    check("mid_rst_bypass", {31'd0, out_bypass1}, 32'd0);
    check("mid_rst_in_ready", {31'd0, in_ready1}, 32'd1);
    #1 rst_n = 1'b1;
    in_valid = 1'b1; in_state = S_B; in_last = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      check("after_rst_idx", {30'd0, out_idx1}, i);
      check("after_rst_col", out_col1, exp_b_sh[i]);
      check("after_rst_bypass", {31'd0, out_bypass1}, 32'd0);
    end
    @(negedge clk);
    check("after_rst_done_valid", {31'd0, out_valid1}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/aes_sr_column_feeder.md
AES_SR_COLUMN_FEEDER -- requirements
Module: aes_sr_column_feeder

Interface
REQ-001 Parameter: SHIFT_EN, default 1, 1 = apply ShiftRows at capture, 0 = capture state unshifted.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  upstream 128-bit state available.
REQ-005 in_ready  output  1  block can capture in_state this cycle.
REQ-006 in_state  input  128  AES state, column c = bits [32c+:32], row r of column c = bits [32c+8r+:8].
REQ-007 in_last  input  1  state belongs to the final round, i.e. MixColumns is to be bypassed downstream.
REQ-008 out_valid  output  1  out_col holds a valid column.
REQ-009 out_ready  input  1  downstream single-column MixColumns stage accepts out_col.
REQ-010 out_col  output  32  current column, row r at bits [8r+:8].
REQ-011 out_idx  output  2  index of the column on out_col (0..3).
REQ-012 out_last_col  output  1  high when out_idx == 3 and out_valid.
REQ-013 out_bypass  output  1  registered copy of in_last for the state being emitted.

Function
REQ-014 The block SHALL implement a two-state FSM: IDLE and EMIT.
REQ-015 Input transfer SHALL occur only on cycles where in_valid && in_ready; output transfer SHALL occur only on cycles where out_valid && out_ready.
REQ-016 With SHIFT_EN=1, the captured byte at row r, column c SHALL be the in_state byte at row r, column (c+r) mod 4; with SHIFT_EN=0, it SHALL be the in_state byte at row r, column c.
REQ-017 IDLE: in_ready=1, out_valid=0; on input transfer, capture the state into a 128-bit register, capture in_last, set idx=0, and go to EMIT.
REQ-018 EMIT: out_valid=1, out_col = captured column idx, out_idx=idx; out_col, out_idx and out_bypass SHALL be driven from registers only.
REQ-019 Latency: the first column SHALL be valid on the cycle following the input transfer.
REQ-020 When out_valid && !out_ready, out_col, out_idx and out_bypass SHALL hold stable.
REQ-021 In EMIT, on an output transfer with idx<3, idx SHALL increment by 1.
REQ-022 In EMIT, in_ready SHALL equal (idx==3 && out_ready); in all other EMIT cycles in_ready SHALL be 0.
REQ-023 On an output transfer with idx==3 and a simultaneous input transfer, the block SHALL capture the new state, set idx=0 and stay in EMIT (back-to-back, no bubble, 4 cycles/state).
REQ-024 On an output transfer with idx==3 and no input transfer, the FSM SHALL return to IDLE.
REQ-025 idx SHALL never wrap from 3 to 0 except through a new capture.
REQ-026 An in_valid asserted while in_ready=0 SHALL be ignored; upstream holds it.

Reset
REQ-027 While rst_n=0, regardless of clk: FSM=IDLE, idx=0, state register=0, out_valid=0, out_col=0, out_idx=0, out_bypass=0, out_last_col=0.
REQ-028 Reset asserted during EMIT SHALL discard the partially emitted state; after release, the block SHALL accept a fresh state with in_ready=1.
REQ-029 After release, in_ready SHALL be 1 and the first capture SHALL be possible on the first rising edge.

Verification
REQ-030 FIPS-197 round-1 post-SubBytes state d42711aee0bf98f1b8b45de51e415230 (first byte at bits [7:0]), SHIFT_EN=1, out_ready=1 -> out_col sequence 305dbfd4, ae52b4e0, f11141b8, e598271e with out_idx 0..3, out_last_col only on the fourth column.
REQ-031 Same state with SHIFT_EN=0 -> out_col sequence ae1127d4, f198bfe0, e55db4b8, 3052411e.
REQ-032 Two states presented back-to-back with out_ready=1 -> 8 consecutive valid columns, no idle cycle; in_ready high only on the idx==3 cycles.
REQ-033 Random out_ready stalls -> out_col stable during stalls, no column lost or duplicated, order 0..3 preserved.
REQ-034 in_last=1 on capture -> out_bypass=1 for all four columns; the next state captured with in_last=0 -> out_bypass=0.
REQ-035 rst_n pulled low mid-EMIT at idx=2 (asynchronously, between edges) -> out_valid=0 immediately; after release, a new state is emitted starting at idx 0.
